// File: rtl/imm_extend_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Shared definitions for the immediate generator. Holds the
//               format-select encodings, the buffer depth and the check that
//               rejects unsupported XLEN values at elaboration.
// Contents    : imm_sel_t      3-bit format select type
//               IMM_U..IMM_ILL format select encodings
//               IMM_BUF_DEPTH  elastic buffer depth
//               xlen_is_legal  returns 1 for XLEN 32 or 64
// Revision    : 1.0  initial release
// ============================================================================
package imm_pkg;

    typedef logic [2:0] imm_sel_t;

    localparam imm_sel_t IMM_U   = 3'b000;
    localparam imm_sel_t IMM_I   = 3'b001;
    localparam imm_sel_t IMM_SH  = 3'b010;
    localparam imm_sel_t IMM_S   = 3'b011;
    localparam imm_sel_t IMM_B   = 3'b100;
    localparam imm_sel_t IMM_J   = 3'b101;
    localparam imm_sel_t IMM_Z   = 3'b110;
    localparam imm_sel_t IMM_ILL = 3'b111;

    localparam int IMM_BUF_DEPTH = 2;

    function automatic bit xlen_is_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_extend_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe_if
// Description : Valid/ready bundle between decode, the immediate generator
//               and execute.
// Ports       : in_valid/in_ready/in_instr/in_sel/in_tag  upstream beat
//               out_valid/out_ready/out_imm/out_tag/out_err downstream beat
// Modports    : master  producer of input beats, consumer of results (bench)
//               slave   the immediate generator itself
// Revision    : 1.0  initial release
// ============================================================================
interface imm_extend_pipe_if
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    imm_sel_t         in_sel;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_instr, in_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_instr, in_sel, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );

endinterface
`default_nettype wire

// File: rtl/imm_extend_pipe_core.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_core
// Description : Purely combinational immediate extraction. Builds the 32-bit
//               immediate for the selected format, then sign- or zero-extends
//               it to XLEN. Select 111 yields zero with the error flag set.
// Ports       : i_instr  [31:0]      raw instruction word
//               i_sel    [2:0]       format select
//               o_imm    [XLEN-1:0]  extended immediate
//               o_err                illegal select
// Revision    : 1.0  initial release
// ============================================================================
module imm_extend_core
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  imm_sel_t        i_sel,
    output logic [XLEN-1:0] o_imm,
    output logic            o_err
);

    // 32-bit form of the immediate; every signed format is already
    // sign-extended to bit 31 here, so widening to 64 only replicates bit 31.
    logic [31:0] w_val32;
    logic        w_signed;

    always_comb begin
        w_val32  = '0;
        w_signed = 1'b0;
        o_err    = 1'b0;
        case (i_sel)
            IMM_U: begin
                w_val32  = {i_instr[31:12], 12'b0};
                w_signed = 1'b1;
            end
            IMM_I: begin
                w_val32  = {{20{i_instr[31]}}, i_instr[31:20]};
                w_signed = 1'b1;
            end
            IMM_SH: begin
                // RV64 shift amounts are 6 bits wide, RV32 only 5.
                if (XLEN == 64) begin
                    w_val32 = {26'b0, i_instr[25:20]};
                end else begin
                    w_val32 = {27'b0, i_instr[24:20]};
                end
            end
            IMM_S: begin
                w_val32  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                w_signed = 1'b1;
            end
            IMM_B: begin
                w_val32  = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
                w_signed = 1'b1;
            end
            IMM_J: begin
                w_val32  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                            i_instr[20], i_instr[30:21], 1'b0};
                w_signed = 1'b1;
            end
            IMM_Z: begin
                w_val32 = {27'b0, i_instr[19:15]};
            end
            default: begin
                o_err = 1'b1;
            end
        endcase
    end

    generate
        if (XLEN == 64) begin : g_xlen64
            assign o_imm = w_signed ? {{32{w_val32[31]}}, w_val32} : {32'b0, w_val32};
        end else begin : g_xlen32
            assign o_imm = w_val32;
        end
    endgenerate

    // The opcode field never contributes to an immediate, and the sign flag
    // is only consumed by the 64-bit widening path.
    logic w_unused;
    assign w_unused = ^{i_instr[6:0], w_signed};

endmodule
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe
// Description : Registered, flow-controlled immediate generator for decode.
//               Each accepted beat is extended combinationally and written
//               into a 2-entry circular buffer; all outputs are driven from
//               the buffer head, so nothing on the output side depends
//               combinationally on the input side.
// Ports       : clk       rising-edge clock
//               reset_n   asynchronous active-low reset
//               flush     synchronous flush, drops every buffered entry
//               bus       imm_extend_pipe_if.slave
//                           in_valid/in_ready/in_instr/in_sel/in_tag
//                           out_valid/out_ready/out_imm/out_tag/out_err
// Revision    : 1.0  initial release
// ============================================================================
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    imm_extend_pipe_if.slave bus
);

    localparam logic [1:0] c_count_full = 2'd2;

    generate
        if (!xlen_is_legal(XLEN)) begin : g_bad_xlen
            $error("imm_extend_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Immediate extraction on the input side
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_imm;
    logic            w_err;

    imm_extend_core #(
        .XLEN (XLEN)
    ) u_core (
        .i_instr (bus.in_instr),
        .i_sel   (bus.in_sel),
        .o_imm   (w_imm),
        .o_err   (w_err)
    );

    // ------------------------------------------------------------------
    // Buffer state
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  r_imm [IMM_BUF_DEPTH];
    logic [TAG_W-1:0] r_tag [IMM_BUF_DEPTH];
    logic             r_err [IMM_BUF_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_in_ready;

    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_nxt;

    assign w_out_valid = (r_count != 2'd0);
    // A beat offered during flush is discarded along with the buffer.
    assign w_push      = bus.in_valid & r_in_ready & ~flush;
    assign w_pop       = w_out_valid & bus.out_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = 2'd0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_in_ready <= 1'b0;
            for (int k = 0; k < IMM_BUF_DEPTH; k++) begin
                r_imm[k] <= '0;
                r_tag[k] <= '0;
                r_err[k] <= 1'b0;
            end
        end else begin
            r_count    <= w_count_nxt;
            // Ready is precomputed from the next occupancy so it stays a
            // plain flop output, independent of out_ready in the same cycle.
            r_in_ready <= (w_count_nxt != c_count_full);
            if (flush) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_imm[r_wr_ptr] <= w_imm;
                    r_tag[r_wr_ptr] <= bus.in_tag;
                    r_err[r_wr_ptr] <= w_err;
                    r_wr_ptr        <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head of the buffer. The head slot is never written while it
    // holds a valid entry, so the payload is stable under stall.
    // ------------------------------------------------------------------
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_imm   = r_imm[r_rd_ptr];
    assign bus.out_tag   = r_tag[r_rd_ptr];
    assign bus.out_err   = r_err[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_pipe
// Description : Self-checking bench for imm_extend_pipe. Drives an XLEN=32
//               and an XLEN=64 instance with identical stimulus: a vector
//               table, hand-written stall/flush/reset sequences and a
//               randomized stream scored against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_imm_extend_pipe;
    import imm_pkg::*;

    logic clk;
    logic reset_n;
    logic flush;

    imm_extend_pipe_if #(.XLEN(32), .TAG_W(5)) if32 ();
    imm_extend_pipe_if #(.XLEN(64), .TAG_W(5)) if64 ();

    assign if64.in_valid  = if32.in_valid;
    assign if64.in_instr  = if32.in_instr;
    assign if64.in_sel    = if32.in_sel;
    assign if64.in_tag    = if32.in_tag;
    assign if64.out_ready = if32.out_ready;

    imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (if32)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (if64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference ----------------
    function automatic longint sx(input longint f, input int bits);
        longint lim;
        lim = 64'sd1 <<< (bits - 1);
        return (f >= lim) ? f - (lim * 2) : f;
    endfunction

    function automatic logic [63:0] model_imm(input logic [31:0] ins, input int sel, input int xlen);
        longint w;
        longint v;
        w = longint'({32'b0, ins});
        case (sel)
            0: v = sx(w & 64'sh0000_0000_FFFF_F000, 32);
            1: v = sx((w >> 20) & 64'sh0FFF, 12);
            2: v = (w >> 20) & ((xlen == 32) ? 64'sh1F : 64'sh3F);
            3: v = sx((((w >> 25) & 64'sh7F) << 5) + ((w >> 7) & 64'sh1F), 12);
            4: v = sx((((w >> 31) & 1) << 12) + (((w >> 7) & 1) << 11) +
                      (((w >> 25) & 64'sh3F) << 5) + (((w >> 8) & 64'shF) << 1), 13);
            5: v = sx((((w >> 31) & 1) << 20) + (((w >> 12) & 64'shFF) << 12) +
                      (((w >> 20) & 1) << 11) + (((w >> 21) & 64'sh3FF) << 1), 21);
            6: v = (w >> 15) & 64'sh1F;
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'sh0000_0000_FFFF_FFFF;
        return 64'(v);
    endfunction

    typedef struct {
        logic [63:0] imm32;
        logic [63:0] imm64;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [4:0]  tag;
        logic [63:0] e32;
        logic [63:0] e64;
        logic        err;
    } vec_t;

    vec_t vecs [12];
    exp_t sb [$];

    task automatic drive(input logic [31:0] ins, input logic [2:0] sel, input logic [4:0] tag);
        if32.in_instr = ins;
        if32.in_sel   = sel;
        if32.in_tag   = tag;
    endtask

    task automatic chk_head(input string name, input logic [63:0] e32, input logic [63:0] e64,
                            input logic [4:0] tag, input logic err);
        chk({name, ".imm32"}, {32'b0, if32.out_imm}, e32);
        chk({name, ".imm64"}, if64.out_imm, e64);
        chk({name, ".tag"}, {59'b0, if32.out_tag}, {59'b0, tag});
        chk({name, ".err"}, {63'b0, if32.out_err}, {63'b0, err});
        chk({name, ".err64"}, {63'b0, if64.out_err}, {63'b0, err});
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, ".out_valid"}, {63'b0, if32.out_valid}, 64'd0);
        chk({name, ".out_valid64"}, {63'b0, if64.out_valid}, 64'd0);
        chk_head(name, 64'd0, 64'd0, 5'd0, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 3'b001, 5'd1,  64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1]  = '{32'h123450B7, 3'b000, 5'd2,  64'h12345000, 64'h0000000012345000, 1'b0};
        vecs[2]  = '{32'hFE20AE23, 3'b011, 5'd3,  64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[3]  = '{32'hFE000EE3, 3'b100, 5'd4,  64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[4]  = '{32'h4010D093, 3'b010, 5'd5,  64'h00000001, 64'h0000000000000001, 1'b0};
        vecs[5]  = '{32'h800000B7, 3'b000, 5'd6,  64'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vecs[6]  = '{32'h03F0D093, 3'b010, 5'd7,  64'h0000001F, 64'h000000000000003F, 1'b0};
        vecs[7]  = '{32'h000FD073, 3'b110, 5'd8,  64'h0000001F, 64'h000000000000001F, 1'b0};
        vecs[8]  = '{32'hFFDFF06F, 3'b101, 5'd9,  64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[9]  = '{32'hFFFFFFFF, 3'b111, 5'd10, 64'h00000000, 64'h0000000000000000, 1'b1};
        vecs[10] = '{32'h7FF00013, 3'b001, 5'd11, 64'h000007FF, 64'h00000000000007FF, 1'b0};
        vecs[11] = '{32'h00208463, 3'b100, 5'd31, 64'h00000008, 64'h0000000000000008, 1'b0};

        reset_n        = 1'b0;
        flush          = 1'b0;
        if32.in_valid  = 1'b0;
        if32.out_ready = 1'b0;
        drive(32'h0, 3'b000, 5'd0);

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("reset.in_ready", {63'b0, if32.in_ready}, 64'd0);
        chk_zero_outputs("reset");
        reset_n = 1'b1;
        tick();
        chk("release.in_ready", {63'b0, if32.in_ready}, 64'd1);
        chk("release.in_ready64", {63'b0, if64.in_ready}, 64'd1);

        // ---------------- vector table, one beat at a time ----------------
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].instr, vecs[i].sel, vecs[i].tag);
            if32.in_valid  = 1'b1;
            if32.out_ready = 1'b1;
            tick();
            if32.in_valid = 1'b0;
            chk($sformatf("vec%0d.out_valid", i), {63'b0, if32.out_valid}, 64'd1);
            chk_head($sformatf("vec%0d", i), vecs[i].e32, vecs[i].e64, vecs[i].tag, vecs[i].err);
            tick();
            chk($sformatf("vec%0d.drained", i), {63'b0, if32.out_valid}, 64'd0);
        end

        // ---------------- back-to-back, one result per cycle ----------------
        if32.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            drive(vecs[k].instr, vecs[k].sel, vecs[k].tag);
            if32.in_valid = 1'b1;
            tick();
            chk($sformatf("b2b%0d.out_valid", k), {63'b0, if32.out_valid}, 64'd1);
            chk($sformatf("b2b%0d.in_ready", k), {63'b0, if32.in_ready}, 64'd1);
            chk_head($sformatf("b2b%0d", k), vecs[k].e32, vecs[k].e64, vecs[k].tag, 1'b0);
        end
        if32.in_valid = 1'b0;
        tick();
        chk("b2b.drained", {63'b0, if32.out_valid}, 64'd0);

        // ---------------- stall: fill, block, release in order ----------------
        if32.out_ready = 1'b0;
        if32.in_valid  = 1'b1;
        drive(vecs[1].instr, vecs[1].sel, 5'd10);
        tick();
        chk("stall.a.in_ready", {63'b0, if32.in_ready}, 64'd1);
        chk("stall.a.tag", {59'b0, if32.out_tag}, 64'd10);
        drive(vecs[2].instr, vecs[2].sel, 5'd11);
        tick();
        chk("stall.full.in_ready", {63'b0, if32.in_ready}, 64'd0);
        chk("stall.full.tag", {59'b0, if32.out_tag}, 64'd10);
        drive(vecs[3].instr, vecs[3].sel, 5'd12);
        tick();
        chk("stall.hold.in_ready", {63'b0, if32.in_ready}, 64'd0);
        chk_head("stall.hold", vecs[1].e32, vecs[1].e64, 5'd10, 1'b0);
        if32.out_ready = 1'b1;
        tick();
        chk("stall.pop1.in_ready", {63'b0, if32.in_ready}, 64'd1);
        chk_head("stall.pop1", vecs[2].e32, vecs[2].e64, 5'd11, 1'b0);
        tick();
        chk("stall.pop2.out_valid", {63'b0, if32.out_valid}, 64'd1);
        chk_head("stall.pop2", vecs[3].e32, vecs[3].e64, 5'd12, 1'b0);
        if32.in_valid = 1'b0;
        tick();
        chk("stall.empty.out_valid", {63'b0, if32.out_valid}, 64'd0);
        chk("stall.empty.in_ready", {63'b0, if32.in_ready}, 64'd1);

        // ---------------- flush when full, with in_valid held ----------------
        if32.out_ready = 1'b0;
        if32.in_valid  = 1'b1;
        drive(vecs[0].instr, vecs[0].sel, 5'd20);
        tick();
        drive(vecs[5].instr, vecs[5].sel, 5'd21);
        tick();
        chk("flush2.pre.in_ready", {63'b0, if32.in_ready}, 64'd0);
        flush = 1'b1;
        tick();
        flush         = 1'b0;
        if32.in_valid = 1'b0;
        chk("flush2.out_valid", {63'b0, if32.out_valid}, 64'd0);
        chk("flush2.in_ready", {63'b0, if32.in_ready}, 64'd1);
        tick();
        chk("flush2.after.out_valid", {63'b0, if32.out_valid}, 64'd0);

        // ---------------- flush at count=1 with a coincident push ----------------
        if32.in_valid = 1'b1;
        drive(vecs[6].instr, vecs[6].sel, 5'd22);
        tick();
        flush = 1'b1;
        drive(vecs[7].instr, vecs[7].sel, 5'd23);
        tick();
        flush         = 1'b0;
        if32.in_valid = 1'b0;
        chk("flush1.out_valid", {63'b0, if32.out_valid}, 64'd0);
        tick();
        chk("flush1.dropped.out_valid", {63'b0, if32.out_valid}, 64'd0);
        chk("flush1.dropped.in_ready", {63'b0, if32.in_ready}, 64'd1);

        // ---------------- randomized stream vs. model ----------------
        sb.delete();
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            logic [2:0]  sel;
            logic [4:0]  tag;
            bit          do_push;
            bit          do_pop;
            ins = $urandom;
            sel = 3'($urandom_range(0, 7));
            tag = 5'($urandom_range(0, 31));
            drive(ins, sel, tag);
            if32.in_valid  = ($urandom_range(0, 3) != 0);
            if32.out_ready = ($urandom_range(0, 3) != 0);
            flush          = ($urandom_range(0, 39) == 0);

            chk("rnd.out_valid", {63'b0, if32.out_valid}, {63'b0, (sb.size() != 0)});
            chk("rnd.in_ready", {63'b0, if32.in_ready}, {63'b0, (sb.size() != 2)});
            if (sb.size() != 0) begin
                chk_head("rnd", sb[0].imm32, sb[0].imm64, sb[0].tag, sb[0].err);
            end

            do_push = if32.in_valid && (sb.size() < 2) && !flush;
            do_pop  = (sb.size() != 0) && if32.out_ready;
            tick();
            if (flush) begin
                sb.delete();
            end else begin
                if (do_pop) void'(sb.pop_front());
                if (do_push) sb.push_back('{model_imm(ins, int'(sel), 32),
                                            model_imm(ins, int'(sel), 64),
                                            tag, (sel == 3'b111)});
            end
        end
        flush          = 1'b0;
        if32.in_valid  = 1'b0;
        if32.out_ready = 1'b1;
        tick();
        tick();
        chk("rnd.drained", {63'b0, if32.out_valid}, 64'd0);

        // ---------------- reset mid-stall at count=1 ----------------
        if32.out_ready = 1'b0;
        if32.in_valid  = 1'b1;
        drive(vecs[0].instr, vecs[0].sel, 5'd7);
        tick();
        if32.in_valid = 1'b0;
        chk("rst.pre.out_valid", {63'b0, if32.out_valid}, 64'd1);
        chk_head("rst.pre", vecs[0].e32, vecs[0].e64, 5'd7, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst.async.in_ready", {63'b0, if32.in_ready}, 64'd0);
        chk_zero_outputs("rst.async");
        tick();
        chk("rst.held.in_ready", {63'b0, if32.in_ready}, 64'd0);
        reset_n = 1'b1;
        tick();
        chk("rst.release.in_ready", {63'b0, if32.in_ready}, 64'd1);
        chk_zero_outputs("rst.release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
